// File: rtl/btime_pkg.sv
// Shared types and constants for the ROM download loader.
package btime_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REG_PROG  = 2'd0,
        REG_SOUND = 2'd1,
        REG_TILES = 2'd2,
        REG_BGMAP = 2'd3
    } region_t;

    localparam logic [24:0] R0_BASE = 25'h000_0000;
    localparam logic [24:0] R0_SIZE = 25'h000_C000;
    localparam logic [24:0] R1_BASE = 25'h000_C000;
    localparam logic [24:0] R1_SIZE = 25'h000_1000;
    localparam logic [24:0] R2_BASE = 25'h000_D000;
    localparam logic [24:0] R2_SIZE = 25'h000_C000;
    localparam logic [24:0] R3_BASE = 25'h001_9000;
    localparam logic [24:0] R3_SIZE = 25'h000_1000;

    localparam logic [16:0] EXP_LEN_DEF = 17'h1A000;

    // One-hot write-enable lane for a region
    function automatic logic [3:0] region_onehot(region_t r);
        case (r)
            REG_PROG:  return 4'b0001;
            REG_SOUND: return 4'b0010;
            REG_TILES: return 4'b0100;
            default:   return 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/btime_rom_loader_dec.sv
// Address-to-region decoder: picks the ROM region for a download byte address
// and returns the offset within it. Pure combinational.
module btime_region_dec
    import btime_pkg::*;
(
    input  logic [24:0] addr_i,
    output region_t     region_o,
    output logic [15:0] offset_o,
    output logic        in_range_o
);

    logic [24:0] base;

    // Region selection; addresses past the last region decode as out of range
    always_comb begin
        region_o   = REG_PROG;
        base       = R0_BASE;
        in_range_o = 1'b1;
        if (addr_i < R0_BASE + R0_SIZE) begin
            region_o = REG_PROG;
            base     = R0_BASE;
        end else if (addr_i < R1_BASE + R1_SIZE) begin
            region_o = REG_SOUND;
            base     = R1_BASE;
        end else if (addr_i < R2_BASE + R2_SIZE) begin
            region_o = REG_TILES;
            base     = R2_BASE;
        end else if (addr_i < R3_BASE + R3_SIZE) begin
            region_o = REG_BGMAP;
            base     = R3_BASE;
        end else begin
            in_range_o = 1'b0;
        end
    end

    assign offset_o = 16'(addr_i - base);

endmodule

// File: rtl/btime_rom_loader.sv
// ROM download loader: steers ioctl download bytes into four ROM regions,
// holds the game core in reset during and shortly after the transfer, and
// reports length/overflow errors plus a running checksum.
//
// state | meaning
// IDLE  | after reset, core held in reset, waiting for a download
// LOAD  | download active, accepting bytes
// HOLD  | download ended, core reset held for HOLD_CYCLES cycles
// RUN   | core released; load_done reflects whether the image was clean
module btime_rom_loader
    import btime_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter logic [16:0] EXP_LEN     = EXP_LEN_DEF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [3:0]  rom_we,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        core_reset,
    output logic        load_done,
    output logic        err_ovf,
    output logic        err_short,
    output logic [15:0] checksum
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

    state_t         state_q;
    logic [HCW-1:0] hold_cnt_q;
    logic [17:0]    byte_cnt_q, byte_cnt_d;
    logic [15:0]    checksum_q, checksum_d;
    logic [3:0]     rom_we_q;
    logic [15:0]    rom_addr_q;
    logic [7:0]     rom_data_q;
    logic           core_reset_q, load_done_q, err_ovf_q, err_short_q;

    region_t        dec_region;
    logic [15:0]    dec_offset;
    logic           dec_in_range;

    logic           wr_live, in_len, wr_hit, wr_ovf, enter_load;

    btime_region_dec u_dec (
        .addr_i     (ioctl_addr),
        .region_o   (dec_region),
        .offset_o   (dec_offset),
        .in_range_o (dec_in_range)
    );

    // A strobe only counts while LOAD is active and download is still high
    assign wr_live    = ioctl_wr && ioctl_download && (state_q == ST_LOAD);
    assign in_len     = ioctl_addr < {8'b0, EXP_LEN};
    assign wr_hit     = wr_live && in_len && dec_in_range;
    assign wr_ovf     = wr_live && !in_len;
    assign enter_load = ioctl_download && (state_q != ST_LOAD);

    // Saturating byte count and modulo-2^16 checksum for the next accepted byte
    always_comb begin
        byte_cnt_d = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 18'd1;
        checksum_d = checksum_q + {8'b0, ioctl_dout};
    end

    // Sequencer FSM with registered outputs and write datapath
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            checksum_q   <= '0;
            rom_we_q     <= '0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_short_q  <= 1'b0;
        end else begin
            rom_we_q <= '0;
            if (enter_load) begin
                state_q      <= ST_LOAD;
                byte_cnt_q   <= '0;
                checksum_q   <= '0;
                err_ovf_q    <= 1'b0;
                err_short_q  <= 1'b0;
                core_reset_q <= 1'b1;
                load_done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        if (!ioctl_download) begin
                            state_q     <= ST_HOLD;
                            hold_cnt_q  <= HOLD_LOAD;
                            err_short_q <= (byte_cnt_q != {1'b0, EXP_LEN});
                        end else if (wr_hit) begin
                            rom_we_q   <= region_onehot(dec_region);
                            rom_addr_q <= dec_offset;
                            rom_data_q <= ioctl_dout;
                            byte_cnt_q <= byte_cnt_d;
                            checksum_q <= checksum_d;
                        end else if (wr_ovf) begin
                            err_ovf_q <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (hold_cnt_q == '0) begin
                            state_q      <= ST_RUN;
                            core_reset_q <= 1'b0;
                            load_done_q  <= !err_ovf_q && !err_short_q;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign err_ovf    = err_ovf_q;
    assign err_short  = err_short_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_btime_rom_loader.sv
// Directed bench for btime_rom_loader: boundary-write table plus hand-written
// sequences for hold timing, HOLD re-entry, mid-load reset and full/short loads.
module tb_btime_rom_loader;

    localparam int H = 16;

    logic        clk_sys = 1'b0;
    logic        reset, ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [3:0]  rom_we;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        core_reset, load_done, err_ovf, err_short;
    logic [15:0] checksum;

    int n_cmp  = 0;
    int n_fail = 0;

    btime_rom_loader #(.HOLD_CYCLES(H), .EXP_LEN(17'h1A000)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .err_ovf        (err_ovf),
        .err_short      (err_short),
        .checksum       (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [3:0]  we;
        logic [15:0] off;
    } vec_t;

    vec_t vt[10];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    initial begin
        logic [15:0] sum;
        logic        exp_ovf;
        int          we_cnt[4];
        logic [24:0] a;

        vt[0] = '{25'h000_0000, 8'h11, 4'b0001, 16'h0000};
        vt[1] = '{25'h000_BFFF, 8'h22, 4'b0001, 16'hBFFF};
        vt[2] = '{25'h000_C000, 8'h33, 4'b0010, 16'h0000};
        vt[3] = '{25'h000_CFFF, 8'h44, 4'b0010, 16'h0FFF};
        vt[4] = '{25'h000_D000, 8'h55, 4'b0100, 16'h0000};
        vt[5] = '{25'h001_8FFF, 8'h66, 4'b0100, 16'hBFFF};
        vt[6] = '{25'h001_9000, 8'h77, 4'b1000, 16'h0000};
        vt[7] = '{25'h001_9FFF, 8'h88, 4'b1000, 16'h0FFF};
        vt[8] = '{25'h001_A000, 8'h99, 4'b0000, 16'h0000};
        vt[9] = '{25'h1FF_FFFF, 8'hAA, 4'b0000, 16'h0000};

        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0;
        tick(); tick();
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_rom_we",     32'(rom_we),     32'd0);
        check("rst_rom_addr",   32'(rom_addr),   32'd0);
        check("rst_rom_data",   32'(rom_data),   32'd0);
        check("rst_checksum",   32'(checksum),   32'd0);
        check("rst_err_ovf",    32'(err_ovf),    32'd0);
        check("rst_err_short",  32'(err_short),  32'd0);
        check("rst_load_done",  32'(load_done),  32'd0);
        reset = 1'b0;
        tick();

        // Boundary table
        ioctl_download = 1'b1;
        tick();
        sum = '0; exp_ovf = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_byte(vt[i].addr, vt[i].data);
            if (vt[i].we != 4'b0000) sum = sum + 16'(vt[i].data);
            else exp_ovf = 1'b1;
            check($sformatf("vec%0d_rom_we", i), 32'(rom_we), 32'(vt[i].we));
            if (vt[i].we != 4'b0000) begin
                check($sformatf("vec%0d_rom_addr", i), 32'(rom_addr), 32'(vt[i].off));
                check($sformatf("vec%0d_rom_data", i), 32'(rom_data), 32'(vt[i].data));
            end
            check($sformatf("vec%0d_checksum", i), 32'(checksum), 32'(sum));
            check($sformatf("vec%0d_err_ovf", i), 32'(err_ovf), 32'(exp_ovf));
            tick();
            check($sformatf("vec%0d_we_idle", i), 32'(rom_we), 32'd0);
        end
        // Strobe on the cycle download falls is ignored
        ioctl_download = 1'b0;
        wr_byte(25'h000_0100, 8'hEE);
        check("fall_wr_we",       32'(rom_we),    32'd0);
        check("fall_wr_checksum", 32'(checksum),  32'(sum));
        check("tbl_err_short",    32'(err_short), 32'd1);
        repeat (H) tick();
        check("tbl_run_core_reset", 32'(core_reset), 32'd0);
        check("tbl_run_load_done",  32'(load_done),  32'd0);
        check("tbl_run_err_ovf",    32'(err_ovf),    32'd1);

        // HOLD re-entry when the hold counter reads 5
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) wr_byte(25'(i), 8'h10);
        ioctl_download = 1'b0;
        tick();
        check("hold_err_short", 32'(err_short), 32'd1);
        repeat (10) tick();
        check("hold_core_reset", 32'(core_reset), 32'd1);
        ioctl_download = 1'b1;
        tick();
        check("reenter_core_reset", 32'(core_reset), 32'd1);
        check("reenter_checksum",   32'(checksum),   32'd0);
        check("reenter_err_short",  32'(err_short),  32'd0);
        check("reenter_err_ovf",    32'(err_ovf),    32'd0);
        repeat (H + 2) tick();
        check("reenter_stay_core_reset", 32'(core_reset), 32'd1);

        // Reset pulsed mid-LOAD
        wr_byte(25'h10, 8'h5A);
        wr_byte(25'h11, 8'hA5);
        check("midload_checksum", 32'(checksum), 32'h00FF);
        reset = 1'b1; ioctl_download = 1'b0;
        ioctl_wr = 1'b1; ioctl_addr = 25'h20; ioctl_dout = 8'h01;
        tick();
        reset = 1'b0; ioctl_wr = 1'b0;
        check("midrst_rom_we",     32'(rom_we),     32'd0);
        check("midrst_core_reset", 32'(core_reset), 32'd1);
        check("midrst_checksum",   32'(checksum),   32'd0);
        tick();

        // Full image re-download, data = addr[7:0]
        ioctl_download = 1'b1;
        tick();
        sum = '0;
        for (int b = 0; b < 4; b++) we_cnt[b] = 0;
        for (int i = 0; i < 32'h1A000; i++) begin
            a = 25'(i);
            wr_byte(a, a[7:0]);
            sum = sum + 16'(a[7:0]);
            for (int b = 0; b < 4; b++) if (rom_we[b]) we_cnt[b]++;
        end
        tick();
        check("full_we_idle", 32'(rom_we), 32'd0);
        check("full_we0_cnt", 32'(we_cnt[0]), 32'h0C000);
        check("full_we1_cnt", 32'(we_cnt[1]), 32'h01000);
        check("full_we2_cnt", 32'(we_cnt[2]), 32'h0C000);
        check("full_we3_cnt", 32'(we_cnt[3]), 32'h01000);
        check("full_checksum", 32'(checksum), 32'(sum));
        check("full_err_ovf",  32'(err_ovf),  32'd0);
        ioctl_download = 1'b0;
        tick();
        check("full_err_short", 32'(err_short), 32'd0);
        repeat (H - 1) tick();
        check("full_core_reset_held", 32'(core_reset), 32'd1);
        check("full_load_done_early", 32'(load_done),  32'd0);
        tick();
        check("full_core_reset_rel", 32'(core_reset), 32'd0);
        check("full_load_done",      32'(load_done),  32'd1);

        // Strobe in RUN is ignored
        wr_byte(25'h5, 8'hFF);
        check("run_wr_we",       32'(rom_we),    32'd0);
        check("run_wr_checksum", 32'(checksum),  32'(sum));
        check("run_load_done",   32'(load_done), 32'd1);

        // Short load of 0x100 bytes
        ioctl_download = 1'b1;
        tick();
        check("short_entry_checksum",  32'(checksum),   32'd0);
        check("short_entry_load_done", 32'(load_done),  32'd0);
        check("short_entry_core_rst",  32'(core_reset), 32'd1);
        sum = '0;
        for (int i = 0; i < 256; i++) begin
            a = 25'(i);
            wr_byte(a, a[7:0]);
            sum = sum + 16'(a[7:0]);
        end
        check("short_checksum", 32'(checksum), 32'h7F80);
        ioctl_download = 1'b0;
        tick();
        check("short_err_short", 32'(err_short), 32'd1);
        check("short_err_ovf",   32'(err_ovf),   32'd0);
        repeat (H) tick();
        check("short_run_core_reset", 32'(core_reset), 32'd0);
        check("short_run_load_done",  32'(load_done),  32'd0);
        check("short_run_checksum",   32'(checksum),   32'(sum));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/btime_rom_loader.md
BTIME_ROM_LOADER -- requirements
Module: btime_rom_loader

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: number of clk_sys cycles core_reset stays high after a download ends.
REQ-002 Parameter EXP_LEN, default 17'h1A000: expected total download length in bytes.
REQ-003 clk_sys  in  1: single clock, 12 MHz, sole clock of the block.
REQ-004 reset  in  1: synchronous active-high reset.
REQ-005 ioctl_download  in  1: high for the whole duration of a ROM transfer.
REQ-006 ioctl_wr  in  1: one-cycle strobe, byte valid.
REQ-007 ioctl_addr  in  25: byte address of ioctl_dout.
REQ-008 ioctl_dout  in  8: download byte.
REQ-009 rom_we  out  4: one-hot write enable for ROM regions 0..3.
REQ-010 rom_addr  out  16: byte offset within the selected region.
REQ-011 rom_data  out  8: registered copy of ioctl_dout.
REQ-012 core_reset  out  1: reset to the game core.
REQ-013 load_done  out  1: high in RUN state after a download that met all checks.
REQ-014 err_ovf  out  1: sticky flag, a write arrived at addr >= EXP_LEN.
REQ-015 err_short  out  1: sticky flag, download ended with byte count != EXP_LEN.
REQ-016 checksum  out  16: modulo-2^16 sum of all accepted bytes.

Function
REQ-017 Region map:
- R0 prog 0x00000-0x0BFFF
- R1 sound 0x0C000-0x0CFFF
- R2 tiles 0x0D000-0x18FFF
- R3 bgmap 0x19000-0x19FFF
REQ-018 rom_addr = ioctl_addr minus the region base, truncated to 16 bits.
REQ-019 FSM states: IDLE, LOAD, HOLD, RUN.
REQ-020 IDLE: core_reset=1; ioctl_download=1 -> LOAD.
REQ-021 LOAD: core_reset=1; ioctl_download=0 -> HOLD, with err_short evaluated on that transition.
REQ-022 HOLD: core_reset=1; down-counter loaded with HOLD_CYCLES-1 on entry; at 0 -> RUN; ioctl_download=1 -> LOAD.
REQ-023 RUN: core_reset=0; ioctl_download=1 -> LOAD.
REQ-024 Every entry to LOAD clears byte count, checksum, err_ovf and err_short in the same cycle.
REQ-025 Write latency:
- ioctl_wr in LOAD with addr < EXP_LEN produces exactly one rom_we pulse 1 cycle later.
- rom_addr and rom_data are valid in that same cycle.
- byte count +1 and checksum +byte.
REQ-026 rom_we is all zeros in any cycle without an accepted write.
REQ-027 ioctl_wr with addr >= EXP_LEN: no rom_we, byte not counted or summed, err_ovf set.
REQ-028 ioctl_wr outside LOAD (including the cycle ioctl_download falls) is ignored entirely.
REQ-029 Byte count is 18 bits and saturates at 2^18-1; the count is not address-based, so duplicate addresses count twice.
REQ-030 load_done = RUN and not err_ovf and not err_short.
REQ-031 A download that fails the checks still reaches RUN after HOLD; only load_done stays low.

Reset
REQ-032 On reset: state=IDLE, core_reset=1, rom_we=0, rom_addr=0, rom_data=0, counters/checksum=0, err flags=0, load_done=0.
REQ-033 Reset during LOAD aborts the transfer; state stays IDLE until the next rising ioctl_download.
REQ-034 If ioctl_download is already high when reset deasserts, LOAD is entered the next cycle.

Structure
REQ-035 Package btime_pkg holds:
- state enum
- region base/size constants R0..R3
- EXP_LEN default
- region-index typedef
REQ-036 The address-to-region decoder is a combinational sub-module btime_region_dec (addr -> region index, offset, in_range); everything else lives in btime_rom_loader.

Verification
REQ-037 Full load of 0x1A000 bytes, data = addr[7:0]:
- rom_we[0] count 0xC000, [1] 0x1000, [2] 0xC000, [3] 0x1000.
- checksum equals the model.
- err flags 0.
- core_reset falls exactly HOLD_CYCLES cycles after ioctl_download falls; load_done=1.
REQ-038 Boundary writes:
- addr 0x0BFFF -> rom_we=0001, rom_addr=0xBFFF.
- addr 0x0C000 -> rom_we=0010, rom_addr=0x0000.
- addr 0x19FFF -> rom_we=1000, rom_addr=0x0FFF.
REQ-039 Write at 0x1A000 gives no rom_we and err_ovf=1; a load of 0x100 bytes gives err_short=1 and load_done=0 in RUN.
REQ-040 reset pulsed mid-LOAD: next cycle rom_we=0, core_reset=1, checksum=0; a re-download then completes normally.
REQ-041 ioctl_download rises during HOLD with counter=5: state returns to LOAD, core_reset stays 1, counters clear; ioctl_wr while in RUN is ignored.
